// File: rtl/gate_measure_ctrl.sv
// Gate/count measurement controller: synchronises the signal under test, generates the
// preset and edge-aligned gates, counts reference clocks and signal edges, and flags timeouts.
module gate_measure_ctrl #(
    parameter int unsigned GATE_LOW  = 12_500_000,
    parameter int unsigned SELF_HALF = 25
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        sig_in,
    input  logic [2:0]  pattern,
    input  logic [29:0] key_gate_time,
    input  logic [29:0] key_time_max,
    input  logic        renew,
    output logic        gate,
    output logic        act_gate,
    output logic [31:0] cnt_ref,
    output logic [31:0] cnt_sig,
    output logic        result_valid,
    output logic        timeout
);
    localparam int SW = (SELF_HALF > 1) ? $clog2(SELF_HALF) : 1;
    localparam logic [2:0] P_PERIOD = 3'd2;
    localparam logic [2:0] P_SELF   = 3'd3;

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_MEAS, S_CLOSE, S_DONE} state_t;

    state_t        state_q;
    logic [SW-1:0] self_cnt_q;
    logic          tone_q;
    logic [2:0]    sync_q;
    logic [31:0]   low_q;
    logic [29:0]   gcnt_q, wd_q, gt_q, tmax_q;
    logic [2:0]    pat_q;
    logic [31:0]   ref_int_q, sig_int_q;
    logic          gate_q, act_q, valid_q, tmo_q;
    logic [31:0]   cnt_ref_q, cnt_sig_q;

    logic          src, sig_edge, pat_ok, in_run, close_now, gate_hit, wd_hit;
    logic [29:0]   gcnt_d, wd_d;
    logic [31:0]   ref_d, sig_d;

    assign src       = (pattern == P_SELF) ? tone_q : sig_in;
    assign sig_edge  = sync_q[1] & ~sync_q[2];
    assign pat_ok    = pattern inside {3'd1, 3'd2, 3'd3};
    assign in_run    = state_q inside {S_ARM, S_MEAS, S_CLOSE};
    assign gcnt_d    = gcnt_q + 30'd1;
    assign wd_d      = wd_q + 30'd1;
    assign gate_hit  = gcnt_d >= gt_q;
    assign wd_hit    = wd_d >= tmax_q;
    assign ref_d     = (ref_int_q == '1) ? ref_int_q : ref_int_q + 32'd1;
    assign sig_d     = (sig_int_q == '1) ? sig_int_q : sig_int_q + 32'd1;
    // A closing edge wins over a watchdog expiry on the same cycle.
    assign close_now = sig_edge & ((state_q == S_CLOSE) | ((state_q == S_MEAS) & (pat_q == P_PERIOD)));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            self_cnt_q <= '0;
            tone_q     <= 1'b0;
            sync_q     <= '0;
        end else begin
            if (pattern != P_SELF) begin
                self_cnt_q <= '0;
                tone_q     <= 1'b0;
            end else if (self_cnt_q == SW'(SELF_HALF - 1)) begin
                self_cnt_q <= '0;
                tone_q     <= ~tone_q;
            end else begin
                self_cnt_q <= self_cnt_q + 1'b1;
            end
            sync_q <= {sync_q[1:0], src};
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= S_IDLE;
            low_q     <= '0;
            gcnt_q    <= '0;
            wd_q      <= '0;
            gt_q      <= '0;
            tmax_q    <= '0;
            pat_q     <= '0;
            ref_int_q <= '0;
            sig_int_q <= '0;
            gate_q    <= 1'b0;
            act_q     <= 1'b0;
            valid_q   <= 1'b0;
            tmo_q     <= 1'b0;
            cnt_ref_q <= '0;
            cnt_sig_q <= '0;
        end else begin
            valid_q <= 1'b0;
            if (renew) begin
                state_q   <= S_IDLE;
                low_q     <= '0;
                gate_q    <= 1'b0;
                act_q     <= 1'b0;
                cnt_ref_q <= '0;
                cnt_sig_q <= '0;
                tmo_q     <= 1'b0;
            end else if (in_run && pattern != pat_q) begin
                state_q <= S_IDLE;
                low_q   <= '0;
                gate_q  <= 1'b0;
                act_q   <= 1'b0;
            end else if (in_run && wd_hit && !close_now) begin
                state_q   <= S_IDLE;
                low_q     <= '0;
                gate_q    <= 1'b0;
                act_q     <= 1'b0;
                cnt_ref_q <= '0;
                cnt_sig_q <= '0;
                tmo_q     <= 1'b1;
                valid_q   <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (pat_ok && (low_q + 32'd1 >= GATE_LOW)) begin
                            state_q   <= S_ARM;
                            low_q     <= '0;
                            gt_q      <= (key_gate_time == '0) ? 30'd1 : key_gate_time;
                            tmax_q    <= key_time_max;
                            pat_q     <= pattern;
                            gcnt_q    <= '0;
                            wd_q      <= '0;
                            ref_int_q <= '0;
                            sig_int_q <= '0;
                            gate_q    <= 1'b1;
                        end else begin
                            low_q <= pat_ok ? low_q + 32'd1 : '0;
                        end
                    end
                    S_ARM: begin
                        gcnt_q <= gcnt_d;
                        wd_q   <= wd_d;
                        if (sig_edge) begin
                            state_q <= S_MEAS;
                            act_q   <= 1'b1;
                        end
                    end
                    S_MEAS: begin
                        gcnt_q    <= gcnt_d;
                        wd_q      <= wd_d;
                        ref_int_q <= ref_d;
                        if (sig_edge) sig_int_q <= sig_d;
                        if (pat_q == P_PERIOD) begin
                            if (sig_edge) begin
                                state_q <= S_DONE;
                                gate_q  <= 1'b0;
                                act_q   <= 1'b0;
                            end
                        end else if (gate_hit) begin
                            state_q <= S_CLOSE;
                            gate_q  <= 1'b0;
                        end
                    end
                    S_CLOSE: begin
                        wd_q      <= wd_d;
                        ref_int_q <= ref_d;
                        if (sig_edge) begin
                            sig_int_q <= sig_d;
                            act_q     <= 1'b0;
                            state_q   <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        cnt_ref_q <= ref_int_q;
                        cnt_sig_q <= sig_int_q;
                        valid_q   <= 1'b1;
                        tmo_q     <= 1'b0;
                        low_q     <= '0;
                        state_q   <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign gate         = gate_q;
    assign act_gate     = act_q;
    assign cnt_ref      = cnt_ref_q;
    assign cnt_sig      = cnt_sig_q;
    assign result_valid = valid_q;
    assign timeout      = tmo_q;
endmodule

// File: doc/gate_measure_ctrl.md
# gate_measure_ctrl

Measurement controller on the consuming side of the keypad mode/gate-time settings. It takes `pattern`, `key_gate_time`, `key_time_max` and `renew`, synchronises the signal under test, and generates the preset gate and the edge-aligned actual gate. Over that gate it counts reference clocks and signal cycles, then hands the counts to the arithmetic/display path with a one-cycle valid pulse. It also detects a disconnected input (timeout) and runs a self-test tone in SELF mode.

## Interface
- `GATE_LOW`, 12_500_000, idle (gate-low) cycles between consecutive measurements
- `SELF_HALF`, 25, half-period in `sys_clk` cycles of the internal self-test tone (25 → 1 MHz at 50 MHz)
- `sys_clk` in 1: system clock, 50 MHz
- `sys_rst_n` in 1: asynchronous, active-low reset
- `sig_in` in 1: signal under test, asynchronous to `sys_clk`
- `pattern` in 3: mode; 0 RESTART, 1 FREQ, 2 PERIOD, 3 SELF, 4 TIME_VARY
- `key_gate_time` in 30: preset gate length in `sys_clk` cycles
- `key_time_max` in 30: watchdog limit in cycles, counted from ARM entry
- `renew` in 1: one-cycle pulse; aborts and restarts measurement
- `gate` out 1: preset gate
- `act_gate` out 1: actual gate, aligned to signal edges
- `cnt_ref` out 32: reference-clock count over the actual gate
- `cnt_sig` out 32: signal rising edges over the actual gate
- `result_valid` out 1: one-cycle pulse when results update
- `timeout` out 1: last measurement ended by the watchdog

## Operation
- Source selection:
  - Measured source is `sig_in` when pattern ≠ 3.
  - In SELF it is an internal tone that toggles every `SELF_HALF` cycles; the tone runs only while pattern = 3 and resets to 0 otherwise.
- Synchronisation:
  - The source passes through 2 flops, then a 3rd flop for edge detection.
  - `edge` = sync2 & ~sync3.
- States: IDLE, ARM, MEAS, CLOSE, DONE.
  - **IDLE**: gate=0, act_gate=0. A low counter runs to `GATE_LOW`, then the block enters ARM, but only if pattern ∈ {1, 2, 3}. For pattern 0, 4 or 5–7 it stays in IDLE, the low counter holds at 0, and the outputs hold their last result.
  - **ARM**: on entry, latch `key_gate_time`, `key_time_max` and `pattern`, and clear the gate counter, watchdog and both count registers. gate=1. On `edge` → MEAS.
  - **MEAS**: act_gate=1. `cnt_ref` increments every cycle; `cnt_sig` increments on each `edge` after the opening edge.
    - FREQ/SELF: when the gate counter (running since ARM entry) reaches the latched gate time, gate drops to 0 → CLOSE.
    - PERIOD: the next `edge` → DONE directly; gate stays 1 until DONE.
  - **CLOSE**: counting continues. On `edge`, `cnt_sig` takes its final increment, act_gate drops → DONE.
  - **DONE**: internal counts are copied to the outputs, result_valid=1, timeout=0 → IDLE.
- Watchdog:
  - Runs in ARM, MEAS and CLOSE.
  - On reaching the latched `key_time_max`: `cnt_ref`=0, `cnt_sig`=0, timeout=1, result_valid pulses, → IDLE.
- Abort:
  - `renew`=1 in any state → IDLE with the low counter cleared. Output counts cleared to 0 and timeout=0; result_valid does not pulse.
  - A change of pattern from the latched value during ARM, MEAS or CLOSE → IDLE without a result pulse; output counts are held.
- Arithmetic:
  - All counters are 32-bit and unsigned.
  - `cnt_ref` and `cnt_sig` saturate at 0xFFFF_FFFF and do not wrap.
  - The 30-bit gate and watchdog counters compare with `>=`, so a setting below the current count terminates on the next cycle.
  - `key_gate_time` = 0 behaves as 1.

## Timing
- Reset values: gate=0, act_gate=0, cnt_ref=0, cnt_sig=0, result_valid=0, timeout=0; FSM in IDLE with the low counter at 0.
- `sig_in` rising edge → `edge` asserted 3 `sys_clk` cycles later.
- act_gate rises on the cycle after `edge` is seen in ARM, and falls on the cycle after the closing `edge`.
- `cnt_ref` = number of cycles with act_gate=1.
- result_valid is exactly 1 cycle wide and rises 1 cycle after act_gate falls. Count outputs change only on that same cycle.
- Simultaneous events:
  - renew beats every other event.
  - The closing `edge` beats the watchdog on the same cycle: a good result is produced.
  - Gate expiry and `edge` on the same cycle in MEAS: count the edge, then → CLOSE.
- Settings inputs are sampled only on ARM entry. Changes mid-measurement do not affect the current run.

## Test plan
- Reset mid-MEAS → all outputs 0 on the following edge; FSM in IDLE; no result_valid pulse.
- FREQ, `key_gate_time`=1000, `GATE_LOW`=10, `sig_in` with 100-cycle period, `key_time_max`=2000 → result_valid with cnt_sig=10 (or 11 by phase) and cnt_ref=10×100 or 11×100, i.e. an exact multiple of 100; gate high 1000 cycles.
- PERIOD, `sig_in` with 37-cycle period → cnt_ref=37, cnt_sig=1; result_valid repeats every measurement.
- SELF, `SELF_HALF`=5, gate=1000 → cnt_ref/cnt_sig = 10.
- `sig_in` held at 0, `key_time_max`=500 → result_valid 500 cycles (±1) after ARM entry; timeout=1, counts 0. Reconnecting the signal then gives a valid result with timeout=0.
- Additional scenarios:
  - `renew` pulse during MEAS → counts cleared, no pulse, new ARM after `GATE_LOW`.
  - Pattern changed to 4 during MEAS → FSM returns to IDLE, counts held, no further ARM while pattern = 4.
